// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame admission scheduler: state width and
// the state encoding shared by the FSM and its debug output.
package frame_scheduler_pkg;

  localparam int FS_STATE_W = 3;

  typedef enum logic [FS_STATE_W-1:0] {
    FS_WAIT_INIT = 3'd0,
    FS_SETTLE    = 3'd1,
    FS_IDLE      = 3'd2,
    FS_PASS      = 3'd3,
    FS_SKIP      = 3'd4
  } fs_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous level input, with rise and
// fall strobes taken from the two oldest stages. Rise and fall are mutually
// exclusive and each lasts exactly one clock.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_v1;
  logic r_v2;
  logic r_v3;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_v1 <= i_sig;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  assign o_rise = r_v2 & ~r_v3;
  assign o_fall = ~r_v2 & r_v3;

endmodule

// File: rtl/frame_scheduler.sv
// Decides which camera frames enter the compression pipeline: holds off
// during sensor init, discards settling frames, then admits one frame in
// every frame_divider while the output buffer is free. frame_gate only ever
// covers whole vsync-delimited frames.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int frame_divider = 1,
  parameter int settle_frames = 2,
  parameter int count_width   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init_active,
  input  logic                   vsync_in,
  input  logic                   buffer_busy,
  output logic                   frame_gate,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic [count_width-1:0] frames_passed,
  output logic [count_width-1:0] frames_dropped,
  output logic [FS_STATE_W-1:0]  state
);

  localparam logic [7:0]             DIV_LAST    = 8'(frame_divider - 1);
  localparam logic [7:0]             SETTLE_LAST = 8'(settle_frames - 1);
  localparam logic [7:0]             BYTE_ONE    = 8'd1;
  localparam logic [count_width-1:0] CNT_ONE     = 1;

  logic w_rise;
  logic w_fall;

  fs_state_e              r_state;
  logic [7:0]             r_divCnt;
  logic [7:0]             r_settleCnt;
  logic                   r_gate;
  logic                   r_start;
  logic                   r_done;
  logic [count_width-1:0] r_passed;
  logic [count_width-1:0] r_dropped;

  sync_edge_detect u_vsyncSync (
    .clock  (clock),
    .reset  (reset),
    .i_sig  (vsync_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Admission FSM with registered gate/pulse outputs and statistics; an
  // init request from any active state aborts the current frame at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= FS_WAIT_INIT;
      r_divCnt    <= '0;
      r_settleCnt <= '0;
      r_gate      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_passed    <= '0;
      r_dropped   <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (init_active && (r_state != FS_WAIT_INIT)) begin
        r_state <= FS_WAIT_INIT;
        r_gate  <= 1'b0;
        r_done  <= (r_state == FS_PASS);
      end else begin
        case (r_state)
          FS_WAIT_INIT: begin
            r_gate <= 1'b0;
            if (!init_active) begin
              r_divCnt    <= '0;
              r_settleCnt <= '0;
              r_state     <= (settle_frames == 0) ? FS_IDLE : FS_SETTLE;
            end
          end
          FS_SETTLE: begin
            if (w_fall) begin
              if (r_settleCnt == SETTLE_LAST) begin
                r_state <= FS_IDLE;
              end else begin
                r_settleCnt <= r_settleCnt + BYTE_ONE;
              end
            end
          end
          FS_IDLE: begin
            if (w_rise) begin
              r_divCnt <= (r_divCnt == DIV_LAST) ? '0 : (r_divCnt + BYTE_ONE);
              if (r_divCnt != '0) begin
                r_state <= FS_SKIP;
              end else if (buffer_busy) begin
                r_state   <= FS_SKIP;
                r_dropped <= r_dropped + CNT_ONE;
              end else begin
                r_state  <= FS_PASS;
                r_gate   <= 1'b1;
                r_start  <= 1'b1;
                r_passed <= r_passed + CNT_ONE;
              end
            end
          end
          FS_PASS: begin
            if (w_fall) begin
              r_state <= FS_IDLE;
              r_gate  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          FS_SKIP: begin
            if (w_fall) begin
              r_state <= FS_IDLE;
            end
          end
          default: begin
            r_state <= FS_WAIT_INIT;
            r_gate  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_gate     = r_gate;
  assign frame_start    = r_start;
  assign frame_done     = r_done;
  assign frames_passed  = r_passed;
  assign frames_dropped = r_dropped;
  assign state          = r_state;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: three instances with different divider/settle/
// counter-width settings share one stimulus stream. Frames are driven as
// vsync windows and each instance's gate/pulse activity is summarised per
// frame and compared with table entries, hand-derived values or a
// frame-level reference model.
module tb_frame_scheduler;

  logic clock;
  logic reset;
  logic initActive;
  logic vsyncIn;
  logic bufferBusy;

  logic        gateA  [3];
  logic        startA [3];
  logic        doneA  [3];
  logic [2:0]  stA    [3];
  logic [15:0] passed0, dropped0, passed1, dropped1;
  logic [3:0]  passed2, dropped2;

  int assertions = 0;
  int failures   = 0;

  int mGate  [3];
  int mFirst [3];
  int mStart [3];
  int mDone  [3];
  int stTrace[256];

  typedef struct {
    int         hi;
    int         lo;
    int         busyFrom;
    int         busyTo;
    logic [2:0] admit;
  } vec_t;

  vec_t tbl[14];

  int divOf   [3] = '{1, 3, 1};
  int settleOf[3] = '{2, 0, 0};
  int cwMod   [3] = '{65536, 65536, 16};
  int settleLeft[3];
  int eligIdx   [3];
  int mdlPassed [3];
  int mdlDropped[3];

  frame_scheduler #(.frame_divider(1), .settle_frames(2), .count_width(16)) dut0 (
    .clock(clock), .reset(reset), .init_active(initActive), .vsync_in(vsyncIn),
    .buffer_busy(bufferBusy), .frame_gate(gateA[0]), .frame_start(startA[0]),
    .frame_done(doneA[0]), .frames_passed(passed0), .frames_dropped(dropped0),
    .state(stA[0]));

  frame_scheduler #(.frame_divider(3), .settle_frames(0), .count_width(16)) dut1 (
    .clock(clock), .reset(reset), .init_active(initActive), .vsync_in(vsyncIn),
    .buffer_busy(bufferBusy), .frame_gate(gateA[1]), .frame_start(startA[1]),
    .frame_done(doneA[1]), .frames_passed(passed1), .frames_dropped(dropped1),
    .state(stA[1]));

  frame_scheduler #(.frame_divider(1), .settle_frames(0), .count_width(4)) dut2 (
    .clock(clock), .reset(reset), .init_active(initActive), .vsync_in(vsyncIn),
    .buffer_busy(bufferBusy), .frame_gate(gateA[2]), .frame_start(startA[2]),
    .frame_done(doneA[2]), .frames_passed(passed2), .frames_dropped(dropped2),
    .state(stA[2]));

  // Free-running 100 MHz-equivalent bench clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearMeas();
    for (int d = 0; d < 3; d++) begin
      mGate[d] = 0; mFirst[d] = -1; mStart[d] = 0; mDone[d] = 0;
    end
  endtask

  task automatic sampleAll(input int c);
    for (int d = 0; d < 3; d++) begin
      if (gateA[d]) begin
        mGate[d]++;
        if (mFirst[d] < 0) mFirst[d] = c;
      end
      if (startA[d]) mStart[d]++;
      if (doneA[d])  mDone[d]++;
    end
    if (c >= 0 && c < 256) stTrace[c] = int'(stA[0]);
  endtask

  // One vsync window: high for hi cycles then low for lo cycles, with optional
  // busy/init/reset windows given in the same cycle index (-1,-1 = none).
  task automatic applyStimulus(input int hi, input int lo, input int bf, input int bt,
                               input int inf, input int intTo, input int rf, input int rt);
    clearMeas();
    for (int c = 0; c < hi + lo; c++) begin
      vsyncIn    = (c < hi);
      bufferBusy = (c >= bf && c < bt);
      initActive = (c >= inf && c < intTo);
      reset      = (c >= rf && c < rt);
      tick();
      sampleAll(c);
    end
    vsyncIn    = 1'b0;
    bufferBusy = 1'b0;
    initActive = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int d, input bit admit, input int hi);
    check($sformatf("%s dut%0d gateCycles", tag, d), mGate[d], admit ? hi : 0);
    check($sformatf("%s dut%0d gateDelay", tag, d), mFirst[d], admit ? 2 : -1);
    check($sformatf("%s dut%0d startPulses", tag, d), mStart[d], admit ? 1 : 0);
    check($sformatf("%s dut%0d donePulses", tag, d), mDone[d], admit ? 1 : 0);
  endtask

  task automatic checkCounters(input string tag, input int p0, input int d0, input int p1,
                               input int d1, input int p2, input int d2);
    check({tag, " dut0 passed"}, int'(passed0), p0);
    check({tag, " dut0 dropped"}, int'(dropped0), d0);
    check({tag, " dut1 passed"}, int'(passed1), p1);
    check({tag, " dut1 dropped"}, int'(dropped1), d1);
    check({tag, " dut2 passed"}, int'(passed2), p2);
    check({tag, " dut2 dropped"}, int'(dropped2), d2);
  endtask

  function automatic int passedOf(input int d);
    case (d)
      0: return int'(passed0);
      1: return int'(passed1);
      default: return int'(passed2);
    endcase
  endfunction

  function automatic int droppedOf(input int d);
    case (d)
      0: return int'(dropped0);
      1: return int'(dropped1);
      default: return int'(dropped2);
    endcase
  endfunction

  initial begin
    // hi, lo, busyFrom, busyTo, admit mask {dut2,dut1,dut0}
    tbl[0]  = '{50, 50, -1, -1, 3'b110};
    tbl[1]  = '{50, 50, -1, -1, 3'b100};
    tbl[2]  = '{50, 50, -1, -1, 3'b101};
    tbl[3]  = '{50, 50, -1, -1, 3'b111};
    tbl[4]  = '{50, 50, -1, -1, 3'b101};
    tbl[5]  = '{20, 10, -1, -1, 3'b101};
    tbl[6]  = '{20, 10, -1, -1, 3'b111};
    tbl[7]  = '{20, 10, -1, -1, 3'b101};
    tbl[8]  = '{20, 10, -1, -1, 3'b101};
    tbl[9]  = '{30, 10,  0, 20, 3'b000};
    tbl[10] = '{30, 10, -1, -1, 3'b101};
    tbl[11] = '{30, 10, 10, 25, 3'b101};
    tbl[12] = '{30, 10, -1, -1, 3'b111};
    tbl[13] = '{ 1,  6, -1, -1, 3'b101};

    reset = 1'b1; initActive = 1'b1; vsyncIn = 1'b0; bufferBusy = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset dut%0d state", d), int'(stA[d]), 0);
      check($sformatf("reset dut%0d gate", d), int'(gateA[d]), 0);
      check($sformatf("reset dut%0d start", d), int'(startA[d]), 0);
      check($sformatf("reset dut%0d done", d), int'(doneA[d]), 0);
    end
    checkCounters("reset", 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    repeat (100) tick();
    check("init hold dut0 state", int'(stA[0]), 0);
    check("init hold dut2 gate", int'(gateA[2]), 0);
    initActive = 1'b0;
    tick();
    check("init done dut0 state", int'(stA[0]), 1);
    check("init done dut2 state", int'(stA[2]), 2);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].hi, tbl[i].lo, tbl[i].busyFrom, tbl[i].busyTo, -1, -1, -1, -1);
      for (int d = 0; d < 3; d++)
        checkOutput($sformatf("vec%0d", i), d, tbl[i].admit[d], tbl[i].hi);
    end
    checkCounters("table", 11, 1, 4, 1, 13, 1);

    // init request in the middle of an admitted frame
    applyStimulus(40, 10, -1, -1, 20, 30, -1, -1);
    check("abort dut0 gateCycles", mGate[0], 18);
    check("abort dut0 startPulses", mStart[0], 1);
    check("abort dut0 donePulses", mDone[0], 1);
    check("abort dut0 state before", stTrace[19], 3);
    check("abort dut0 state at init", stTrace[20], 0);
    check("abort dut0 state held", stTrace[29], 0);
    check("abort dut0 state after", stTrace[30], 1);
    check("abort dut1 gateCycles", mGate[1], 0);
    check("abort dut1 donePulses", mDone[1], 0);
    check("abort dut2 gateCycles", mGate[2], 18);
    check("abort dut2 donePulses", mDone[2], 1);
    checkCounters("abort", 12, 1, 4, 1, 14, 1);

    // IDLE entered while vsync is already high
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    initActive = 1'b1; repeat (5) tick();
    vsyncIn = 1'b1; repeat (5) tick();
    clearMeas();
    initActive = 1'b0;
    for (int c = 0; c < 20; c++) begin tick(); sampleAll(c); end
    vsyncIn = 1'b0;
    for (int c = 20; c < 30; c++) begin tick(); sampleAll(c); end
    check("partial dut1 gateCycles", mGate[1], 0);
    check("partial dut2 gateCycles", mGate[2], 0);
    check("partial dut2 startPulses", mStart[2], 0);
    check("partial dut2 state", int'(stA[2]), 2);
    applyStimulus(20, 10, -1, -1, -1, -1, -1, -1);
    checkOutput("afterPartial", 0, 1'b0, 20);
    checkOutput("afterPartial", 1, 1'b1, 20);
    checkOutput("afterPartial", 2, 1'b1, 20);

    // reset asserted inside an admitted frame, held until vsync is low
    applyStimulus(30, 10, -1, -1, -1, -1, 10, 35);
    check("midReset dut0 gateCycles", mGate[0], 8);
    check("midReset dut0 donePulses", mDone[0], 0);
    check("midReset dut2 gateCycles", mGate[2], 8);
    check("midReset dut2 donePulses", mDone[2], 0);
    checkCounters("midReset", 0, 0, 0, 0, 0, 0);

    // counter wrap: 17 short frames
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    for (int i = 0; i < 17; i++) applyStimulus(3, 4, -1, -1, -1, -1, -1, -1);
    checkCounters("wrap", 15, 0, 6, 0, 1, 0);

    // randomized frames against the frame-level model
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    for (int d = 0; d < 3; d++) begin
      settleLeft[d] = settleOf[d]; eligIdx[d] = 0; mdlPassed[d] = 0; mdlDropped[d] = 0;
    end
    for (int i = 0; i < 40; i++) begin
      int  hi, lo, bf, bt;
      bit  busyRise;
      bit  expAdm[3];
      hi = int'($urandom_range(1, 25));
      lo = int'($urandom_range(3, 12));
      bf = -1; bt = -1;
      if ($urandom_range(0, 3) != 0) begin
        bf = int'($urandom_range(0, hi + lo - 1));
        bt = bf + int'($urandom_range(1, 20));
      end
      busyRise = (2 >= bf) && (2 < bt);
      for (int d = 0; d < 3; d++) begin
        expAdm[d] = 1'b0;
        if (settleLeft[d] > 0) begin
          settleLeft[d]--;
        end else begin
          if (eligIdx[d] % divOf[d] == 0) begin
            if (busyRise) mdlDropped[d]++;
            else begin expAdm[d] = 1'b1; mdlPassed[d]++; end
          end
          eligIdx[d]++;
        end
      end
      applyStimulus(hi, lo, bf, bt, -1, -1, -1, -1);
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("rnd%0d", i), d, expAdm[d], hi);
        check($sformatf("rnd%0d dut%0d passed", i, d), passedOf(d), mdlPassed[d] % cwMod[d]);
        check($sformatf("rnd%0d dut%0d dropped", i, d), droppedOf(d), mdlDropped[d] % cwMod[d]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
